// File: rtl/uart_pkg.sv
// Shared state encoding and sizing helper for the UART transmit arbiter.
// Imported by the arbiter top and its round-robin picker.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART core write/ack handshake.
// slave = arbiter side, master = requesters and UART core side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);

  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           data_tx;
  logic                 data_tx_wr;
  logic                 data_tx_ack;

  modport master (
    output req_data, req_valid, req_last, data_tx_ack,
    input  req_ready, data_tx, data_tx_wr
  );

  modport slave (
    input  req_data, req_valid, req_last, data_tx_ack,
    output req_ready, data_tx, data_tx_wr
  );

endinterface

// File: rtl/uart_rr_picker.sv
// Round-robin winner select: rotate valids by rr_ptr, take lowest set bit, rotate index back.
// Latency: purely combinational. Backpressure: none, the caller decides when to use the winner.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_valid
);

  localparam logic [ID_W:0] N_W = NUM_REQ[ID_W:0];

  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  always_comb begin
    rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, off} + {1'b0, rr_ptr};
    if (sum >= N_W) sum = sum - N_W;
    winner = sum[ID_W-1:0];
  end

  assign any_valid = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin share of one UART transmitter; ack watchdog under UART_TX_ARB_TIMEOUT_EN.
// Latency: valid in IDLE -> LOAD/accept next cycle -> data_tx_wr the cycle after; ack-to-strobe >= 2.
// Backpressure: one byte in flight; only the granted port sees req_ready, and only in LOAD.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF,
  localparam int         ID_W           = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_enable,
  uart_tx_arbiter_if.slave   bus,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] next_ptr;
  logic            any_valid;
  logic            accept;
  logic            last_q;
  logic [7:0]      cur_byte;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign cur_byte = bus.req_data[{grant_id, 3'b000} +: 8];
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
  assign busy     = (state != IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Counts ack-less WAIT_ACK cycles already elapsed; zero on entry.
  logic [15:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wd_cnt <= '0;
    else if (state != WAIT_ACK)  wd_cnt <= '0;
    else if (!bus.data_tx_ack)   wd_cnt <= wd_cnt + 16'd1;
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    accept        = 1'b0;
    timeout_err   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_enable && any_valid) state_nxt = LOAD;
      end
      LOAD: begin
        // Grant stays locked here until the granted port offers its next byte.
        bus.req_ready[grant_id] = bus.req_valid[grant_id];
        accept                  = bus.req_valid[grant_id];
        if (accept) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.data_tx_ack) begin
          state_nxt = last_q ? IDLE : LOAD;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (wd_cnt == TIMEOUT_CYCLES - 16'd1) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant_id       <= '0;
      last_q         <= 1'b0;
      bus.data_tx    <= '0;
      bus.data_tx_wr <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.data_tx_wr <= accept;
      if (state == IDLE && state_nxt == LOAD) grant_id <= winner;
      if (accept) begin
        bus.data_tx <= cur_byte;
        last_q      <= bus.req_last[grant_id];
      end
      // Covers both the last-byte ack and a watchdog abort.
      if (state == WAIT_ACK && state_nxt == IDLE) rr_ptr <= next_ptr;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboarded bench: requester feeders and a UART core model around uart_tx_arbiter.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ = 2;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         gap;
  } ent_t;

  typedef struct {
    logic [7:0] d;
    logic [0:0] g;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tx_enable = 1'b1;
  logic [0:0] grant_id;
  logic       busy;
  logic       timeout_err;

  ent_t rq[NREQ][$];
  int   gap_left[NREQ];
  exp_t exp_q[$];
  int   strobe_cyc[$];

  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;
  int cyc = 0;
  int ack_dly = 5;
  bit ack_en = 1'b1;
  bit spur_ack = 1'b0;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(16'd16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_enable   (tx_enable),
    .bus         (bus.slave),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required $finish");
    $fatal(1);
  end

  // Requester feeders: present queue heads, pop on handshake, honour idle gaps.
  initial begin : feeder
    logic [NREQ-1:0] hs;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
        if (rq[i].size() > 0) begin
          if (rq[i][0].gap > 0) begin
            if (gap_left[i] == 0) gap_left[i] = rq[i][0].gap;
            gap_left[i]--;
            if (gap_left[i] == 0) void'(rq[i].pop_front());
          end else begin
            bus.req_valid[i]      = 1'b1;
            bus.req_data[8*i +: 8] = rq[i][0].d;
            bus.req_last[i]       = rq[i][0].last;
          end
        end
      end
    end
  end

  // UART core model: scoreboard each strobe, ack ack_dly cycles later (0 = same cycle).
  initial begin : core
    int   ack_cnt;
    exp_t e;
    ack_cnt = -1;
    bus.data_tx_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ack_cnt = -1;
        bus.data_tx_ack = 1'b0;
        continue;
      end
      if (bus.data_tx_wr) begin
        strobes++;
        strobe_cyc.push_back(cyc);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: data_tx=%h grant=%0d, required no strobe", bus.data_tx, grant_id);
        end else begin
          e = exp_q.pop_front();
          if (bus.data_tx !== e.d || grant_id !== e.g) begin
            miscompares++;
            $display("FAIL sb_byte: data_tx=%h grant=%0d, required data_tx=%h grant=%0d",
                     bus.data_tx, grant_id, e.d, e.g);
          end
        end
        if (ack_en) ack_cnt = ack_dly;
      end
      bus.data_tx_ack = spur_ack;
      if (ack_cnt == 0) begin
        bus.data_tx_ack = 1'b1;
        ack_cnt = -1;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
      end
    end
  end

  task automatic push(input int r, input logic [7:0] d, input logic last);
    ent_t e;
    exp_t x;
    e.d = d; e.last = last; e.gap = 0;
    rq[r].push_back(e);
    x.d = d; x.g = 1'(r);
    exp_q.push_back(x);
  endtask

  task automatic push_gap(input int r, input int n);
    ent_t e;
    e.d = 8'h00; e.last = 1'b0; e.gap = n;
    rq[r].push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rq[i].delete();
      gap_left[i] = 0;
    end
    exp_q.delete();
    strobe_cyc.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack_en = 1'b1;
    ack_dly = 5;
    spur_ack = 1'b0;
    tx_enable = 1'b1;
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus.data_tx_wr === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dut.state !== IDLE || dut.rr_ptr !== 1'b0 || grant_id !== 1'b0 || bus.data_tx !== 8'h00 ||
        bus.data_tx_wr !== 1'b0 || bus.req_ready !== 2'b00 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: state=%0d rr=%0d gid=%0d tx=%h wr=%b rdy=%b busy=%b to=%b, required all 0",
               dut.state, dut.rr_ptr, grant_id, bus.data_tx, bus.data_tx_wr, bus.req_ready, busy, timeout_err);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || bus.data_tx_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b wr=%b, required 0 0", busy, bus.data_tx_wr);
    end
  endtask

  task automatic test_single_packet();
    bit ok;
    int s0;
    do_reset();
    s0 = strobes;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    wait_drain(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    vectors++;
    if (dut.rr_ptr !== 1'b1) begin
      miscompares++;
      $display("FAIL single_rr_ptr: rr_ptr=%0d, required 1", dut.rr_ptr);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if (strobes - s0 != 2) begin
      miscompares++;
      $display("FAIL single_strobes: %0d strobes, required 2", strobes - s0);
    end
  endtask

  task automatic test_two_packets();
    bit ok;
    do_reset();
    push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
    push(1, 8'hB0, 1'b0); push(1, 8'hB1, 1'b0); push(1, 8'hB2, 1'b1);
    wait_drain(400, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL two_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    vectors++;
    if (dut.rr_ptr !== 1'b0) begin
      miscompares++;
      $display("FAIL two_rr_wrap: rr_ptr=%0d, required 0", dut.rr_ptr);
    end
  endtask

  task automatic test_hold_mid_packet();
    bit ok;
    bit bad;
    do_reset();
    ack_dly = 0;
    push(0, 8'hC0, 1'b0);
    push_gap(0, 10);
    push(0, 8'hC1, 1'b0);
    push(0, 8'hC2, 1'b1);
    push(1, 8'hD0, 1'b1);
    wait_strobe(50, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hold_first_strobe: no strobe, required C0 strobe");
    end
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (dut.state !== LOAD || grant_id !== 1'b0 || bus.req_ready[1] !== 1'b0) begin
        bad = 1'b1;
        $display("FAIL hold_locked: state=%0d gid=%0d rdy1=%b, required LOAD 0 0",
                 dut.state, grant_id, bus.req_ready[1]);
      end
    end
    vectors++;
    if (bad) miscompares++;
    wait_drain(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL hold_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_tx_enable();
    bit ok;
    bit bad;
    int s0;
    do_reset();
    @(negedge clk);
    tx_enable = 1'b0;
    spur_ack = 1'b1;
    s0 = strobes;
    push(0, 8'h55, 1'b1);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0) bad = 1'b1;
    end
    vectors++;
    if (bad || strobes != s0) begin
      miscompares++;
      $display("FAIL txen_gated: busy_seen=%b strobes=%0d, required 0 0", bad, strobes - s0);
    end
    spur_ack = 1'b0;
    @(posedge clk);
    #1 tx_enable = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || bus.data_tx_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL txen_cyc0: busy=%b wr=%b, required 0 0", busy, bus.data_tx_wr);
    end
    @(negedge clk);
    vectors++;
    if (dut.state !== LOAD || bus.req_ready !== 2'b01 || bus.data_tx_wr !== 1'b0) begin
      miscompares++;
      $display("FAIL txen_cyc1: state=%0d rdy=%b wr=%b, required LOAD 01 0", dut.state, bus.req_ready, bus.data_tx_wr);
    end
    @(negedge clk);
    vectors++;
    if (bus.data_tx_wr !== 1'b1 || bus.data_tx !== 8'h55) begin
      miscompares++;
      $display("FAIL txen_cyc2: wr=%b tx=%h, required 1 55", bus.data_tx_wr, bus.data_tx);
    end
    wait_drain(100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL txen_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_ack_same_cycle();
    bit ok;
    do_reset();
    ack_dly = 0;
    push(0, 8'h61, 1'b0);
    push(0, 8'h62, 1'b1);
    wait_drain(100, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL samecyc_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
    vectors++;
    if (strobe_cyc.size() != 2 || strobe_cyc[1] - strobe_cyc[0] != 2) begin
      miscompares++;
      $display("FAIL samecyc_gap: strobes=%0d gap=%0d, required 2 strobes gap 2",
               strobe_cyc.size(), (strobe_cyc.size() == 2) ? strobe_cyc[1] - strobe_cyc[0] : -1);
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    do_reset();
    ack_en = 1'b0;
    push(0, 8'h71, 1'b1);
    push(1, 8'h81, 1'b1);
    wait_strobe(50, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wd_strobe: no strobe, required 71 strobe");
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int n;
      n = 1;
      while (timeout_err !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (timeout_err !== 1'b1 || n != 16) begin
        miscompares++;
        $display("FAIL wd_pulse_cycle: cycle=%0d err=%b, required 16 1", n, timeout_err);
      end
      ack_en = 1'b1;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || timeout_err !== 1'b0) begin
        miscompares++;
        $display("FAIL wd_after: busy=%b err=%b, required 0 0", busy, timeout_err);
      end
      wait_drain(100, ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL wd_next_grant: pending=%0d busy=%b, required 0 0", exp_q.size(), busy);
      end
    end
`else
    begin
      bit bad;
      bad = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (busy !== 1'b1 || timeout_err !== 1'b0) bad = 1'b1;
      end
      vectors++;
      if (bad || exp_q.size() != 1) begin
        miscompares++;
        $display("FAIL wd_wait_forever: dropped=%b pending=%0d, required 0 1", bad, exp_q.size());
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    ack_en = 1'b0;
    push(0, 8'h93, 1'b1);
    wait_strobe(50, ok);
    repeat (2) @(negedge clk);
    vectors++;
    if (!ok || dut.state !== WAIT_ACK) begin
      miscompares++;
      $display("FAIL rstmid_setup: state=%0d, required WAIT_ACK", dut.state);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.data_tx !== 8'h00 || bus.data_tx_wr !== 1'b0 || bus.req_ready !== 2'b00 ||
        grant_id !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0 || dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL rstmid_outputs: tx=%h wr=%b rdy=%b gid=%0d busy=%b to=%b, required all 0",
               bus.data_tx, bus.data_tx_wr, bus.req_ready, grant_id, busy, timeout_err);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_two_packets();
    test_hold_mid_packet();
    test_tx_enable();
    test_ack_same_cycle();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. CPU register path, debug logger and boot messages.
- Packet-granular round-robin: a grant is held from the first byte until the byte flagged last.
- Drives the UART core's data_tx / data_tx_wr / data_tx_ack handshake.
- Sits between the requester streams and the UART core.

Parameters:
- NUM_REQ, 2, number of requester ports (2..8).
- TIMEOUT_CYCLES, 16'hFFFF, ack watchdog limit in clk cycles; used only with UART_TX_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- tx_enable  input  1  CR tx_enable; gates new grants.
- req_data  input  8*NUM_REQ  byte per requester; requester i uses bits [8i+7:8i].
- req_valid  input  NUM_REQ  byte valid per requester.
- req_last  input  NUM_REQ  byte is the last of its packet.
- req_ready  output  NUM_REQ  byte accepted (combinational).
- data_tx  output  8  byte to the UART core.
- data_tx_wr  output  1  one-cycle write strobe to the UART core.
- data_tx_ack  input  1  one-cycle pulse: core has consumed the byte.
- grant_id  output  $clog2(NUM_REQ)  current/last granted requester.
- busy  output  1  state != IDLE.
- timeout_err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active low.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, data_tx=0, data_tx_wr=0, req_ready=0, busy=0, timeout_err=0.
- FSM states: IDLE, LOAD, WAIT_ACK.
- IDLE:
  - If tx_enable and |req_valid: grant_id <= first requester with valid, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - req_ready[grant_id] = req_valid[grant_id]; all other ready bits are 0.
  - On handshake: data_tx <= byte, last_q <= req_last[grant_id], data_tx_wr <= 1 for one cycle, go to WAIT_ACK.
  - Without valid, stay in LOAD; the grant stays locked mid-packet.
  - tx_enable is ignored once a packet has started.
- WAIT_ACK:
  - data_tx is held stable.
  - data_tx_ack is honoured on any cycle in this state, including the cycle data_tx_wr is high.
  - On ack with last_q=1: go to IDLE, rr_ptr <= grant_id+1 mod NUM_REQ.
  - On ack with last_q=0: go to LOAD.
- Latency, valid at IDLE (cycle 0): LOAD at cycle 1, ready and accept in cycle 1, data_tx_wr high in cycle 2.
- Ack-to-next-strobe minimum is 2 cycles, via LOAD.
- A single-byte packet has req_last=1 on its first byte.
- Throughput is at most one byte per UART ack; no buffering.
- data_tx_ack outside WAIT_ACK is ignored.
- Simultaneous valid on all ports: strict rotation, so each requester gets one packet before any repeats.
- rr_ptr wrap: NUM_REQ-1 wraps to 0.
- Reset mid-operation: the FSM returns to IDLE at once and the in-flight byte is dropped; the UART core resets on the same rst_n.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to WAIT_ACK and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES: timeout_err pulses for one cycle, state goes to IDLE, rr_ptr advances past grant_id.
  - The rest of that requester's packet is treated as a new packet at its next grant.
- Without the macro: no counter, timeout_err is tied to 0, WAIT_ACK waits indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package uart_pkg holds:
  - the state encoding constants (IDLE=2'd0, LOAD=2'd1, WAIT_ACK=2'd2);
  - the ID width function, $clog2 with a floor of 1.
- One sub-module, uart_rr_picker:
  - combinational rotate-priority-rotate;
  - inputs req_valid and rr_ptr; outputs winner index and any_valid.

Test Plan:
- Single requester 0 sends packet {8'h41, 8'h42 last}, core acks 5 cycles after each strobe → data_tx 41 then 42, exactly two data_tx_wr pulses, busy falls and rr_ptr=1 after the second ack.
- Requesters 0 and 1 both valid with 3-byte packets {A0,A1,A2} and {B0,B1,B2} → byte order A0 A1 A2 B0 B1 B2 with no interleave; grant_id=1 during the B bytes.
- Requester 0 drops valid for 10 cycles mid-packet while requester 1 is valid → state stays LOAD, grant_id=0, req_ready[1]=0 throughout.
- tx_enable=0 with valid asserted → no data_tx_wr for 100 cycles; tx_enable=1 → first strobe 2 cycles later.
- Ack in the same cycle as data_tx_wr → accepted; next strobe 2 cycles later.
- Timeout (macro on, TIMEOUT_CYCLES=16), no ack → timeout_err pulses at cycle 16 of WAIT_ACK, busy=0 next cycle, requester 1 granted next. Separately, rst_n asserted in WAIT_ACK → all outputs 0 immediately.
